// File: rtl/rf_access_seq_pkg.sv
// Shared encodings for the register-file access sequencer: request opcodes,
// the R3 (debug-mapped) register index and the default RF address width.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 2
`endif

package rf_access_seq_pkg;

   localparam logic [1:0] OP_LD   = 2'b00;
   localparam logic [1:0] OP_ST   = 2'b01;
   localparam logic [1:0] OP_SWAP = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   localparam int DEFAULT_REG_ADDR_W = `REG_ADDR_WIDTH;

   // R3 reads are redirected to the debug register inside the RF.
   localparam int R3_IDX = 3;

endpackage

// File: rtl/rf_seq_bypass_cache.sv
// One-entry write cache (addr, data, valid) that lets loads of recently
// stored registers skip the RF read. Only instantiated under RF_SEQ_BYPASS_EN.
module rf_seq_bypass_cache
   import rf_access_seq_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic [REG_ADDR_WIDTH-1:0] lookup_addr,
   output logic                      hit,
   output logic [DATA_WIDTH-1:0]     hit_data
);

   localparam logic [REG_ADDR_WIDTH-1:0] R3_ADDR = REG_ADDR_WIDTH'(R3_IDX);

   logic                      valid_q;
   logic [REG_ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]     data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (wr_en) begin
         valid_q <= 1'b1;
         addr_q  <= wr_addr;
         data_q  <= wr_data;
      end
   end

   // R3 never hits: its RF read returns the debug value, not what was stored.
   assign hit      = valid_q && (addr_q == lookup_addr) && (lookup_addr != R3_ADDR);
   assign hit_data = data_q;

endmodule

// File: rtl/rf_access_seq.sv
// Register-file load/store initiator: sequences LD/ST/SWAP requests into
// rf_ld_ce/rf_st_ce strobes and returns read data. RF_SEQ_BYPASS_EN adds a write cache.
module rf_access_seq
   import rf_access_seq_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [1:0]                req_op,
   input  logic [REG_ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_data,
   output logic                      rsp_err,
   output logic                      rf_ld_ce,
   output logic                      rf_st_ce,
   output logic [REG_ADDR_WIDTH-1:0] rf_addr,
   output logic [DATA_WIDTH-1:0]     rf_acc,
   input  logic [DATA_WIDTH-1:0]     rf_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_RSP
   } state_e;

   state_e                    state_q, state_d;
   logic [1:0]                op_q;
   logic [REG_ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [DATA_WIDTH-1:0]     rsp_data_q;
   logic                      err_q;
   logic                      accept;
   logic                      hit;
   logic [DATA_WIDTH-1:0]     hit_data;
   logic                      cache_wr;

   assign accept   = req_valid && req_ready;
   assign cache_wr = (state_q == S_WR);

`ifdef RF_SEQ_BYPASS_EN
   rf_seq_bypass_cache #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_cache (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (cache_wr),
      .wr_addr     (addr_q),
      .wr_data     (wdata_q),
      .lookup_addr (req_addr),
      .hit         (hit),
      .hit_data    (hit_data)
   );
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               case (req_op)
                  OP_LD:   state_d = hit ? S_RSP : S_RD;
                  OP_ST:   state_d = S_WR;
                  OP_SWAP: state_d = S_RD;
                  default: state_d = S_RSP;
               endcase
            end
         end
         S_RD:    state_d = S_CAP;
         S_CAP:   state_d = (op_q == OP_SWAP) ? S_WR : S_RSP;
         S_WR:    state_d = S_RSP;
         S_RSP:   if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request fields are held from accept so rf_addr stays stable through RSP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q       <= OP_LD;
         addr_q     <= '0;
         wdata_q    <= '0;
         rsp_data_q <= '0;
         err_q      <= 1'b0;
      end else if (accept) begin
         op_q       <= req_op;
         addr_q     <= req_addr;
         wdata_q    <= req_wdata;
         err_q      <= (req_op == OP_RSVD);
         rsp_data_q <= ((req_op == OP_LD) && hit) ? hit_data : '0;
      end else if (state_q == S_CAP) begin
         rsp_data_q <= rf_data;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RSP);
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_data  = rsp_data_q;
   assign rf_ld_ce  = (state_q == S_RD);
   assign rf_st_ce  = (state_q == S_WR);
   assign rf_addr   = addr_q;
   assign rf_acc    = wdata_q;

endmodule

// File: tb/tb_rf_access_seq.sv
// Scoreboard bench for rf_access_seq with a behavioural RF (R3 reads return
// a debug value); expectations follow RF_SEQ_BYPASS_EN when it is defined.
module tb_rf_access_seq;

   localparam logic [7:0] DEBUG_VAL = 8'hD3;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid, req_ready;
   logic [1:0] req_op;
   logic [1:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid, rsp_ready, rsp_err;
   logic [7:0] rsp_data;
   logic       rf_ld_ce, rf_st_ce;
   logic [1:0] rf_addr;
   logic [7:0] rf_acc;
   logic [7:0] rf_data = 8'h00;

   rf_access_seq dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .rf_ld_ce  (rf_ld_ce),
      .rf_st_ce  (rf_st_ce),
      .rf_addr   (rf_addr),
      .rf_acc    (rf_acc),
      .rf_data   (rf_data)
   );

   always #5 clk = ~clk;

   // Behavioural RF: registered read, R3 reads mapped to the debug register.
   logic [7:0] rf_regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
   int         rf_wr_cnt = 0;

   always @(posedge clk) begin
      if (rf_ld_ce) rf_data <= (rf_addr == 2'd3) ? DEBUG_VAL : rf_regs[rf_addr];
      if (rf_st_ce) begin
         rf_regs[rf_addr] <= rf_acc;
         rf_wr_cnt <= rf_wr_cnt + 1;
      end
   end

   // Strobe monitor, sampled away from the active edge.
   int         ld_total = 0, st_total = 0, both_total = 0;
   logic [1:0] last_ld_addr = 2'd0, last_st_addr = 2'd0;
   logic [7:0] last_st_acc = 8'h00;

   always @(negedge clk) begin
      if (rf_ld_ce) begin
         ld_total++;
         last_ld_addr = rf_addr;
      end
      if (rf_st_ce) begin
         st_total++;
         last_st_addr = rf_addr;
         last_st_acc  = rf_acc;
      end
      if (rf_ld_ce && rf_st_ce) both_total++;
   end

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         lat;
      int         nld;
      int         nst;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] ref_regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
   int         n_checks = 0;
   int         n_fail = 0;

`ifdef RF_SEQ_BYPASS_EN
   logic       c_valid = 1'b0;
   logic [1:0] c_addr = 2'd0;
`endif

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_req(input logic [1:0] op, input logic [1:0] addr,
                          input logic [7:0] wd, input int hold);
      exp_t       e, got;
      int         n, lat, ld0, st0;
      logic       hit;
      logic [7:0] held;
      hit = 1'b0;
`ifdef RF_SEQ_BYPASS_EN
      hit = (op == 2'b00) && c_valid && (c_addr == addr) && (addr != 2'd3);
`endif
      e.err  = (op == 2'b11);
      e.data = 8'h00;
      e.nld  = 0;
      e.nst  = 0;
      e.lat  = 1;
      case (op)
         2'b00: begin
            e.data = (addr == 2'd3) ? DEBUG_VAL : ref_regs[addr];
            e.lat  = hit ? 1 : 3;
            e.nld  = hit ? 0 : 1;
         end
         2'b01: begin
            e.lat = 2;
            e.nst = 1;
            ref_regs[addr] = wd;
         end
         2'b10: begin
            e.data = (addr == 2'd3) ? DEBUG_VAL : ref_regs[addr];
            e.lat  = 4;
            e.nld  = 1;
            e.nst  = 1;
            ref_regs[addr] = wd;
         end
         default: ;
      endcase
`ifdef RF_SEQ_BYPASS_EN
      if (op == 2'b01 || op == 2'b10) begin
         c_valid = 1'b1;
         c_addr  = addr;
      end
`endif
      @(negedge clk);
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check_val("req_ready_timeout", 0, 1);
      ld0 = ld_total;
      st0 = st_total;
      @(posedge clk);
      sb_q.push_back(e);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 50);
      got = sb_q.pop_front();
      check_val("latency", lat, got.lat);
      check_val("rsp_err", rsp_err, got.err);
      check_val("rsp_data", rsp_data, got.data);
      held = rsp_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_val("hold_rsp_valid", rsp_valid, 1);
         check_val("hold_rsp_data", rsp_data, held);
         check_val("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      check_val("rsp_valid_drop", rsp_valid, 0);
      check_val("req_ready_back", req_ready, 1);
      check_val("ld_ce_count", ld_total - ld0, got.nld);
      check_val("st_ce_count", st_total - st0, got.nst);
      if (got.nst != 0) begin
         check_val("st_addr", last_st_addr, addr);
         check_val("st_acc", last_st_acc, wd);
      end
      if (got.nld != 0) check_val("ld_addr", last_ld_addr, addr);
   endtask

   initial begin
      int wr0;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_addr  = 2'd0;
      req_wdata = 8'h00;
      rsp_ready = 1'b0;
      #3;
      check_val("rst_req_ready", req_ready, 1);
      check_val("rst_rsp_valid", rsp_valid, 0);
      check_val("rst_rsp_err", rsp_err, 0);
      check_val("rst_ld_ce", rf_ld_ce, 0);
      check_val("rst_st_ce", rf_st_ce, 0);
      check_val("rst_rf_addr", rf_addr, 0);
      check_val("rst_rf_acc", rf_acc, 0);
      check_val("rst_rsp_data", rsp_data, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_req(2'b01, 2'd1, 8'hA5, 0);   // ST R1
      run_req(2'b00, 2'd1, 8'h00, 0);   // LD R1
      run_req(2'b01, 2'd2, 8'h3C, 0);   // ST R2 old value
      run_req(2'b10, 2'd2, 8'h11, 0);   // SWAP R2 returns 0x3C
      run_req(2'b00, 2'd2, 8'h00, 0);   // LD R2 returns 0x11
      run_req(2'b11, 2'd1, 8'hFF, 0);   // reserved op
      run_req(2'b00, 2'd1, 8'h00, 5);   // response back-pressure

      // Reset while the store strobe is up: the RF must never see the write.
      @(negedge clk);
      req_op    = 2'b01;
      req_addr  = 2'd2;
      req_wdata = 8'h99;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wr0 = rf_wr_cnt;
      @(negedge clk);
      check_val("rstwr_in_wr", rf_st_ce, 1);
      #2 rst = 1'b1;
      #1;
      check_val("rstwr_st_ce", rf_st_ce, 0);
      check_val("rstwr_rsp_valid", rsp_valid, 0);
      check_val("rstwr_req_ready", req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_val("rstwr_no_write", rf_wr_cnt, wr0);
`ifdef RF_SEQ_BYPASS_EN
      c_valid = 1'b0;
`endif
      run_req(2'b00, 2'd2, 8'h00, 0);   // still 0x11

      run_req(2'b01, 2'd3, 8'h55, 0);   // ST R3
      run_req(2'b10, 2'd3, 8'h66, 0);   // SWAP R3 returns debug value
      check_val("r3_stored", rf_regs[3], 8'h66);

      run_req(2'b01, 2'd0, 8'h7E, 0);   // ST R0
      run_req(2'b00, 2'd0, 8'h00, 0);   // LD R0 (bypass hit when enabled)
      run_req(2'b00, 2'd3, 8'h00, 0);   // LD R3 always via RF

      for (int k = 0; k < 12; k++) begin
         run_req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)), $urandom_range(0, 2));
      end

      check_val("strobes_overlap", both_total, 0);
      check_val("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
